// File: rtl/conv_pkg.sv
// Shared constants, group-state encoding and saturating add for the KxK conv MAC.
package conv_pkg;

  localparam int DEF_K  = 3;
  localparam int DEF_DW = 8;
  localparam int DEF_WW = 8;
  localparam int DEF_AW = 32;

  typedef enum logic {
    G_IDLE = 1'b0,   // next beat opens a new group
    G_ACC  = 1'b1    // group in progress
  } gstate_e;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] sum;
  } sat_res_t;

  // Adds two aw-bit signed values carried in 64 bits and clamps the result
  // into the aw-bit signed range. aw must be <= 63 so the raw sum cannot wrap.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int                 aw);
    sat_res_t           r;
    logic signed [63:0] s, hi, lo;
    r  = '0;
    s  = a + b;
    hi = (64'sd1 <<< (aw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.sum = s;
    if (s > hi) begin
      r.sum = hi;
      r.ovf = 1'b1;
    end else if (s < lo) begin
      r.sum = lo;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_mac_tree.sv
// Window dot-product tree: input capture, K*K products, K row sums, window sum.
// Every stage is registered and advances only on en; results are exact.
module conv_mac_tree
  import conv_pkg::*;
#(
  parameter int K  = DEF_K,
  parameter int DW = DEF_DW,
  parameter int WW = DEF_WW
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic                                 in_valid,
  input  logic [K*K*DW-1:0]                    in_win,
  input  logic [K*K*WW-1:0]                    in_wgt,
  input  logic                                 in_last,
  output logic                                 out_valid,
  output logic                                 out_last,
  output logic signed [DW+WW+1+$clog2(K*K)-1:0] out_sum
);

  localparam int N      = K * K;
  localparam int PW     = DW + WW + 1;          // one product
  localparam int RW     = PW + $clog2(K);       // one row of K products
  localparam int SW     = PW + $clog2(N);       // whole window
  localparam int STAGES = 3;                    // 0 capture, 1 prod, 2 row, 3 window

  logic [STAGES:0] vld_pipe;
  logic [STAGES:0] last_pipe;

  logic [N-1:0][DW-1:0] win_q;
  logic [N-1:0][WW-1:0] wgt_q;
  logic signed [PW-1:0] px      [N];
  logic signed [PW-1:0] wx      [N];
  logic signed [PW-1:0] prod_d  [N];
  logic signed [PW-1:0] prod_q  [N];
  logic signed [RW-1:0] row_d   [K];
  logic signed [RW-1:0] row_q   [K];
  logic signed [SW-1:0] win_d;
  logic signed [SW-1:0] win_sum_q;

  // Pixels are unsigned: zero-extend then widen both operands to product width.
  for (genvar i = 0; i < N; i++) begin : g_prod
    assign px[i]     = PW'($signed({1'b0, win_q[i]}));
    assign wx[i]     = PW'($signed(wgt_q[i]));
    assign prod_d[i] = px[i] * wx[i];
  end

  // Row reduction of the registered products.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      row_d[r] = '0;
      for (int c = 0; c < K; c++)
        row_d[r] = row_d[r] + RW'(prod_q[r*K + c]);
    end
  end

  // Window reduction of the registered row sums.
  always_comb begin
    win_d = '0;
    for (int r = 0; r < K; r++)
      win_d = win_d + SW'(row_q[r]);
  end

  // Valid/last shift registers; cleared on reset so in-flight beats vanish.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else if (en) begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], in_valid};
      last_pipe <= {last_pipe[STAGES-1:0], in_last};
    end
  end

  // Datapath registers; qualified by the valid pipe, so no reset needed.
  always_ff @(posedge clk) begin
    if (en) begin
      win_q     <= in_win;
      wgt_q     <= in_wgt;
      for (int i = 0; i < N; i++) prod_q[i] <= prod_d[i];
      for (int r = 0; r < K; r++) row_q[r]  <= row_d[r];
      win_sum_q <= win_d;
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_last  = last_pipe[STAGES];
  assign out_sum   = win_sum_q;

endmodule

// File: rtl/conv_mac_kxk.sv
// KxK convolution MAC: window dot product per beat, accumulated across the
// channel beats of a group with bias, saturation and optional ReLU.
module conv_mac_kxk
  import conv_pkg::*;
#(
  parameter int K  = DEF_K,
  parameter int DW = DEF_DW,
  parameter int WW = DEF_WW,
  parameter int AW = DEF_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K*K*DW-1:0]    in_win,
  input  logic [K*K*WW-1:0]    in_wgt,
  input  logic                 in_last,
  input  logic signed [AW-1:0] cfg_bias,
  input  logic                 cfg_relu,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] out_acc,
  output logic                 out_ovf
);

  localparam int SW = DW + WW + 1 + $clog2(K*K);

  if (K < 1 || K > 7) begin : g_k_chk
    $error("conv_mac_kxk: K must be in 1..7");
  end
  if (AW < SW) begin : g_aw_chk
    $error("conv_mac_kxk: AW too narrow for a lossless window sum");
  end
  if (AW > 63) begin : g_aw_max
    $error("conv_mac_kxk: AW must not exceed 63");
  end

  logic                 en;
  logic                 s3_vld, s3_last;
  logic signed [SW-1:0] s3_sum;
  logic signed [AW-1:0] win_ext;
  logic signed [AW-1:0] acc, base, res_acc;
  logic                 ovf_grp, res_ovf;
  sat_res_t             res;
  logic                 unused_hi;
  gstate_e              gstate, gstate_nxt;

  // Whole pipe freezes only while a result sits unaccepted.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  conv_mac_tree #(.K(K), .DW(DW), .WW(WW)) u_tree (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .in_win   (in_win),
    .in_wgt   (in_wgt),
    .in_last  (in_last),
    .out_valid(s3_vld),
    .out_last (s3_last),
    .out_sum  (s3_sum)
  );

  assign win_ext = AW'(s3_sum);

  // S4 arithmetic: first beat of a group starts from the bias, later beats
  // from the running accumulator; overflow is sticky inside a group.
  always_comb begin
    base      = (gstate == G_IDLE) ? cfg_bias : acc;
    res       = sat_add(64'(base), 64'(win_ext), AW);
    res_acc   = res.sum[AW-1:0];
    res_ovf   = ((gstate == G_IDLE) ? 1'b0 : ovf_grp) | res.ovf;
    unused_hi = ^res.sum[63:AW];
  end

  // Group state register.
  always_ff @(posedge clk) begin
    if (rst) gstate <= G_IDLE;
    else     gstate <= gstate_nxt;
  end

  // Group state transitions on each window reaching S4.
  always_comb begin
    gstate_nxt = gstate;
    if (en && s3_vld) begin
      case (gstate)
        G_IDLE:  if (!s3_last) gstate_nxt = G_ACC;
        G_ACC:   if (s3_last)  gstate_nxt = G_IDLE;
        default: gstate_nxt = G_IDLE;
      endcase
    end
  end

  // Running accumulator and group overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      ovf_grp <= 1'b0;
    end else if (en && s3_vld) begin
      acc     <= res_acc;
      ovf_grp <= res_ovf;
    end
  end

  // Output register: loads on a group's last beat, otherwise drains when taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      if (s3_vld && s3_last) begin
        out_valid <= 1'b1;
        out_acc   <= (cfg_relu && res_acc < 0) ? '0 : res_acc;
        out_ovf   <= res_ovf;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_kxk.sv
// Directed bench: one 32-bit and one 22-bit accumulator instance share stimulus.
module tb_conv_mac_kxk;

  localparam int K   = 3;
  localparam int DW  = 8;
  localparam int WW  = 8;
  localparam int AW  = 32;
  localparam int AW2 = 22;
  localparam int N   = K * K;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid, in_last, cfg_relu, out_ready;
  logic [N*DW-1:0]       in_win;
  logic [N*WW-1:0]       in_wgt;
  logic signed [AW-1:0]  cfg_bias;
  logic                  in_ready, out_valid, out_ovf;
  logic signed [AW-1:0]  out_acc;
  logic                  in_ready2, out_valid2, out_ovf2;
  logic signed [AW2-1:0] out_acc2;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv_mac_kxk #(.K(K), .DW(DW), .WW(WW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_win(in_win), .in_wgt(in_wgt), .in_last(in_last),
    .cfg_bias(cfg_bias), .cfg_relu(cfg_relu),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf)
  );

  conv_mac_kxk #(.K(K), .DW(DW), .WW(WW), .AW(AW2)) dut22 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_win(in_win), .in_wgt(in_wgt), .in_last(in_last),
    .cfg_bias(cfg_bias[AW2-1:0]), .cfg_relu(cfg_relu),
    .out_valid(out_valid2), .out_ready(out_ready), .out_acc(out_acc2), .out_ovf(out_ovf2)
  );

  task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic beat(input logic [7:0] pv, input logic [7:0] wv, input logic last);
    bit done;
    done     = 1'b0;
    in_win   = {N{pv}};
    in_wgt   = {N{wv}};
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        @(posedge clk);
        break;
      end
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  // Wait for a handshaked result and check both instances, then consume it.
  task automatic wait_res(input string tag, input longint e32, input bit o32,
                          input longint e22, input bit o22);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk({tag, "_acc"},    out_acc, e32);
      chk({tag, "_ovf"},    64'(out_ovf), 64'(o32));
      chk({tag, "_vld22"},  64'(out_valid2), 1);
      chk({tag, "_acc22"},  out_acc2, e22);
      chk({tag, "_ovf22"},  64'(out_ovf2), 64'(o22));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_win = '0; in_wgt = '0;
    cfg_bias = '0; cfg_relu = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_vld", 64'(out_valid), 0);
    chk("rst_acc", out_acc, 0);
    chk("rst_ovf", 64'(out_ovf), 0);
    chk("rst_rdy", 64'(in_ready), 1);
    @(posedge clk); #1;

    // Single beat 255 x -128: exact latency of four edges.
    beat(8'd255, 8'h80, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lat_early", 64'(out_valid), 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_vld", 64'(out_valid), 1);
    chk("neg_acc", out_acc, -293760);
    chk("neg_ovf", 64'(out_ovf), 0);
    chk("neg_acc22", out_acc2, -293760);
    @(posedge clk); #1;
    @(negedge clk);
    chk("vld_fall", 64'(out_valid), 0);
    @(posedge clk); #1;

    // Same beat with ReLU clamps to zero.
    cfg_relu = 1'b1;
    beat(8'd255, 8'h80, 1'b1);
    wait_res("relu", 0, 0, 0, 0);
    cfg_relu = 1'b0;

    // Three-beat group with bias and bubbles between beats.
    cfg_bias = 10;
    beat(8'd1, 8'd1, 1'b0);
    repeat (2) @(posedge clk); #1;
    beat(8'd1, 8'd1, 1'b0);
    repeat (3) @(posedge clk); #1;
    beat(8'd1, 8'd1, 1'b1);
    wait_res("grp3", 37, 0, 37, 0);
    cfg_bias = 0;

    // Two single-beat groups into a stalled consumer.
    out_ready = 1'b0;
    beat(8'd1, 8'd1, 1'b1);
    beat(8'd2, 8'd1, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("stall_vld", 64'(out_valid), 1);
    chk("stall_acc", out_acc, 9);
    chk("stall_rdy", 64'(in_ready), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stall_hold", out_acc, 9);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_res("drain1", 9, 0, 9, 0);
    wait_res("drain2", 18, 0, 18, 0);

    // Eight beats of 255 x 127: saturates only the 22-bit instance.
    for (int i = 0; i < 8; i++) beat(8'd255, 8'd127, (i == 7));
    wait_res("sat", 2331720, 0, 2097151, 1);
    beat(8'd1, 8'd1, 1'b1);
    wait_res("post_sat", 9, 0, 9, 0);

    // Partial group thrown away by reset.
    beat(8'd1, 8'd1, 1'b0);
    beat(8'd1, 8'd1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst2_rdy", 64'(in_ready), 1);
    chk("rst2_vld", 64'(out_valid), 0);
    chk("rst2_acc", out_acc, 0);
    @(posedge clk); #1;
    beat(8'd2, 8'd3, 1'b1);
    wait_res("after_rst", 54, 0, 54, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("no_extra", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_mac_kxk.md
CONV_MAC_KXK -- requirements
Module: conv_mac_kxk

Interface
REQ-001 Parameter K, 3, kernel edge; window is K x K elements, K in 1..7.
REQ-002 Parameter DW, 8, unsigned pixel width.
REQ-003 Parameter WW, 8, signed two's-complement weight width.
REQ-004 Parameter AW, 32, signed accumulator/output width; elaboration SHALL fail if AW < DW+WW+1+clog2(K*K).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-007 in_valid  input  1  window beat valid.
REQ-008 in_ready  output  1  block accepts beat this cycle.
REQ-009 in_win  input  K*K*DW  pixels; element (r,c) at bits [(r*K+c)*DW +: DW].
REQ-010 in_wgt  input  K*K*WW  weights; same (r,c) packing with WW.
REQ-011 in_last  input  1  beat is final channel of current output group.
REQ-012 cfg_bias  input  AW  signed bias added once per group.
REQ-013 cfg_relu  input  1  clamp negative results to 0.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  consumer accepts result.
REQ-016 out_acc  output  AW  signed group result.
REQ-017 out_ovf  output  1  accumulator saturated at least once in this group.

Function
REQ-018 Beat accepted on a rising edge where in_valid && in_ready.
REQ-019 Global enable en = !(out_valid && !out_ready); in_ready SHALL equal en; all pipeline stages advance only when en.
REQ-020 S1: K*K products, each signed({1'b0,pixel}) x signed weight, width DW+WW+1, registered.
REQ-021 S2: K row sums registered; S3: window sum registered, sign-extended to AW; S1-S3 lossless.
REQ-022 Group FSM: G_IDLE (next beat is first) and G_ACC; G_IDLE->G_ACC on a non-last beat at S4; G_ACC->G_IDLE on a last beat at S4; a first beat that is also last stays in G_IDLE.
REQ-023 S4 in G_IDLE: acc = sat(cfg_bias + winsum), ovf cleared then set if saturated; in G_ACC: acc = sat(acc + winsum), ovf sticky.
REQ-024 sat() clamps to [-2^(AW-1), 2^(AW-1)-1].
REQ-025 On a last beat at S4: out_acc = (cfg_relu && result<0) ? 0 : result, out_ovf = group ovf, out_valid = 1; ReLU applied after saturation.
REQ-026 Latency: last beat accepted on edge N -> out_valid high after edge N+4 when no stall; exactly one result per group.
REQ-027 out_acc/out_ovf SHALL hold stable while out_valid && !out_ready.
REQ-028 out_valid && out_ready with a new result arriving at S4 on same edge: new result loads, out_valid stays 1; without new result: out_valid falls.
REQ-029 in_valid low mid-group inserts bubbles; group state and acc unaffected.
REQ-030 cfg_bias/cfg_relu SHALL be sampled at S4; stable while any beat in flight (caller rule).

Reset
REQ-031 On rst: out_valid=0, out_acc=0, out_ovf=0, all stage valid bits=0, acc=0, FSM=G_IDLE; in-flight beats and partial groups discarded, never output.
REQ-032 in_ready SHALL be 1 in the cycle after rst deasserts.

Structure
REQ-033 Package conv_pkg holds default DW/WW/AW/K constants, the group-state enum, and a saturating signed-add function.
REQ-034 One sub-module conv_mac_tree implements S1-S3 (products, row sums, window sum) with valid pipeline and enable, parameterised by K, DW, WW.

Verification (K=3, DW=8, WW=8, AW=32 unless noted)
REQ-035 Single beat, win all 255, wgt all -128, bias 0, relu 0, last=1 -> out_acc=-293760, out_ovf=0, out_valid 4 edges after acceptance.
REQ-036 Same stimulus, relu=1 -> out_acc=0.
REQ-037 Three beats win all 1, wgt all 1, bias 10, last on third -> single result 37.
REQ-038 Two back-to-back single-beat groups (results 9, 18), out_ready=0 for 5 cycles -> in_ready low while stalled, 9 held stable, then 9 and 18 in order, none lost.
REQ-039 AW=22, eight beats win 255, wgt 127, bias 0 -> out_acc=2097151, out_ovf=1; next group single beat win 1 wgt 1 -> 9, out_ovf=0.
REQ-040 Two non-last beats, rst one cycle, then single beat win 2 wgt 3 bias 0 -> only output 54.
